lsu: RTL

Load/store unit for the single-cycle RV32I core. It sits between the execute stage's load/store address computation and the data memory, and returns load data to the writeback mux. It converts one core load or store into a word-aligned bus transaction with byte enables, using a req/gnt/rvalid handshake. It stalls the core until the access completes, then returns sign- or zero-extended load data.

---
 rtl/lsu_if.sv | 24 ++
 rtl/lsu.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/lsu_if.sv
// Data-memory bus between the load/store unit and data memory: word-aligned
// req/gnt request phase followed by an rvalid read-data phase.
interface lsu_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/lsu.sv
// Load/store unit: turns one RV32I load/store into a word-aligned bus access
// with byte enables, stalls the core until done, returns extended load data.
module lsu #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_load,
  input  logic              req_store,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic [31:0]       rdata,
  output logic              rvalid,
  output logic              fault,
  lsu_if.master             bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t            state_reg, state_next;
  logic              we_reg;
  logic [2:0]        funct3_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [3:0]        be_reg;
  logic [31:0]       wdata_reg;
  logic [31:0]       rdata_reg;

  logic              request, illegal, misaligned, legal;
  logic [3:0]        be_next;
  logic [31:0]       wdata_next;
  logic [31:0]       lane;
  logic [31:0]       load_ext;

  genvar gi;

  assign request = req_load | req_store;

  always_comb begin
    illegal = 1'b0;
    if (req_load && req_store)
      illegal = 1'b1;
    else if (req_load)
      illegal = !(funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    else if (req_store)
      illegal = !(funct3 inside {3'b000, 3'b001, 3'b010});
  end

  assign misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                      ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
  assign legal      = !illegal && !misaligned;

  always_comb begin
    be_next = 4'b1111;
    case (funct3[1:0])
      2'b00:   be_next = 4'b0001 << addr[1:0];
      2'b01:   be_next = addr[1] ? 4'b1100 : 4'b0011;
      default: be_next = 4'b1111;
    endcase
  end

  // Replicating the byte/half across lanes is the same as shifting it into
  // place, and keeps the unused lanes deterministic.
  generate
    for (gi = 0; gi < 4; gi++) begin : g_wlane
      assign wdata_next[8*gi +: 8] =
        (funct3[1:0] == 2'b00) ? wdata[7:0] :
        (funct3[1:0] == 2'b01) ? wdata[8*(gi%2) +: 8] :
                                 wdata[8*gi +: 8];
    end
  endgenerate

  assign lane = bus.mem_rdata >> {addr_reg[1:0], 3'b000};

  always_comb begin
    load_ext = lane;
    case (funct3_reg)
      3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_ext = {24'd0, lane[7:0]};
      3'b101:  load_ext = {16'd0, lane[15:0]};
      default: load_ext = lane;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      we_reg     <= 1'b0;
      funct3_reg <= 3'b000;
      addr_reg   <= '0;
      be_reg     <= 4'b0000;
      wdata_reg  <= 32'd0;
      rdata_reg  <= 32'd0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && request && legal) begin
        we_reg     <= req_store;
        funct3_reg <= funct3;
        addr_reg   <= addr;
        be_reg     <= be_next;
        wdata_reg  <= wdata_next;
      end
      if (state_reg == WAIT && bus.mem_rvalid)
        rdata_reg <= load_ext;
    end
  end

  always_comb begin
    state_next = state_reg;
    stall      = 1'b0;
    fault      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (request) begin
          if (legal) begin
            stall      = 1'b1;
            state_next = REQ;
          end else begin
            fault = 1'b1;
          end
        end
      end
      REQ: begin
        stall = 1'b1;
        if (bus.mem_gnt)
          state_next = we_reg ? DONE : WAIT;
      end
      WAIT: begin
        stall = 1'b1;
        if (bus.mem_rvalid)
          state_next = DONE;
      end
      // Request inputs still belong to the finishing instruction here.
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign rvalid        = (state_reg == DONE) && !we_reg;
  assign rdata         = rdata_reg;
  assign bus.mem_req   = (state_reg == REQ);
  assign bus.mem_we    = we_reg;
  assign bus.mem_addr  = {addr_reg[ADDR_W-1:2], 2'b00};
  assign bus.mem_be    = be_reg;
  assign bus.mem_wdata = wdata_reg;

endmodule
